// File: rtl/nibble_add_seq.sv
// Multi-cycle W-bit add/subtract sequencer sharing one 4-bit carry-lookahead slice (sum4b).
// Optional subtract support is enabled by defining NIBBLE_ADD_SEQ_SUB_EN.

module sum4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of c_in; no ripple through lower carries.
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_in);

  assign s     = p ^ c[3:0];
  assign c_out = c[4];
endmodule

module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 c_in,
  input  logic                 sub,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 c_out,
  output logic                 zero,
  output logic                 busy
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic          carry;
  logic [KW-1:0] k;

  logic [W-1:0]  opb_in;
  logic          cin_in;
  logic          accept;
  logic          last;
  logic [3:0]    slice_a;
  logic [3:0]    slice_b;
  logic [3:0]    slice_s;
  logic          slice_c;
  logic [W-1:0]  sum_nxt;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  // A - B is A + ~B + 1, so subtract forces the carry-in high and ignores c_in.
  assign opb_in = sub ? ~b : b;
  assign cin_in = sub | c_in;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign opb_in     = b;
  assign cin_in     = c_in;
`endif

  assign start_ready = (state == IDLE) & ~rst;
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign accept      = start_valid & start_ready;
  assign last        = (k == KW'(NIBBLES - 1));

  assign slice_a = opa[4*k +: 4];
  assign slice_b = opb[4*k +: 4];

  sum4b u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry),
    .s     (slice_s),
    .c_out (slice_c)
  );

  // Full sum as it will look after this cycle's nibble write; zero is judged on it.
  always_comb begin
    sum_nxt          = sum;
    sum_nxt[4*k +: 4] = slice_s;
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      c_out <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opa   <= a;
            opb   <= opb_in;
            carry <= cin_in;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum   <= sum_nxt;
          carry <= slice_c;
          if (last) begin
            k     <= '0;
            c_out <= slice_c;
            zero  <= ~|sum_nxt;
            state <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (NIBBLES=4): vector table, random ops against
// an arithmetic model, and hand-written back-pressure / reset / back-to-back sequences.

module tb_nibble_add_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         zero;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int overlap_seen = 0;

  nibble_add_seq #(.NIBBLES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .c_in        (c_in),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .c_out       (c_out),
    .zero        (zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (start_ready && res_valid) overlap_seen <= overlap_seen + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic, borrow-free flag for subtract.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W:0]   r;
    logic [W-1:0] res;
    logic         co;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    if (s) begin
      res = x - y;
      co  = (x >= y);
    end else begin
      r   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      res = r[W-1:0];
      co  = r[W];
    end
`else
    r   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    res = r[W-1:0];
    co  = r[W];
    if (s) co = r[W];
`endif
    return {co, (res == '0), res};
  endfunction

  // Runs one op with res_ready held low until the result appears; returns latency.
  task automatic do_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic s,
                       input logic [W-1:0] es, input logic ec, input logic ez);
    int lat;
    a = x; b = y; c_in = ci; sub = s; start_valid = 1'b1; res_ready = 1'b0;
    check({name, " ready_before"}, 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = ~x; b = ~y; c_in = ~ci;
    check({name, " busy"}, 32'(busy), 32'd1);
    check({name, " ready_after"}, 32'(start_ready), 32'd0);
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(N));
    check({name, " sum"}, 32'(sum), 32'(es));
    check({name, " c_out"}, 32'(c_out), 32'(ec));
    check({name, " zero"}, 32'(zero), 32'(ez));
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({name, " idle"}, 32'(res_valid), 32'd0);
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         s;
    logic [W-1:0] es;
    logic         ec;
    logic         ez;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [W-1:0] held_sum;
    logic         held_c, held_z;
    logic [W+1:0] m;
    int           n_acc, n_res, spurious;
    int           acc_t[2];
    logic [W-1:0] res_q[2];

    vecs[0] = '{"add_5555",   16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"carry_all",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[2] = '{"msb_cin",    16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    vecs[3] = '{"mid_carry",  16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    vecs[4] = '{"sub_5_7",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{"sub_7_5",    16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
`else
    vecs[4] = '{"sub_5_7",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'h000C, 1'b0, 1'b0};
    vecs[5] = '{"sub_7_5",    16'h0007, 16'h0005, 1'b1, 1'b1, 16'h000D, 1'b0, 1'b0};
`endif

    rst = 1'b1; start_valid = 1'b0; res_ready = 1'b0;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    check("rst start_ready", 32'(start_ready), 32'd0);
    check("rst res_valid",   32'(res_valid), 32'd0);
    check("rst busy",        32'(busy), 32'd0);
    check("rst sum",         32'(sum), 32'd0);
    check("rst c_out",       32'(c_out), 32'd0);
    check("rst zero",        32'(zero), 32'd0);
    rst = 1'b0; #1;
    check("post-rst ready",  32'(start_ready), 32'd1);

    for (int i = 0; i < 6; i++)
      do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s,
            vecs[i].es, vecs[i].ec, vecs[i].ez);

    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] x, y;
      logic ci, s;
      x  = W'($urandom);
      y  = (i % 5 == 0) ? x : W'($urandom);
      ci = 1'($urandom);
      s  = 1'($urandom);
      m  = model(x, y, ci, s);
      do_op($sformatf("rand%0d", i), x, y, ci, s, m[W-1:0], m[W+1], m[W]);
    end

    // Back-pressure: hold the result, poke start_valid, expect no second result.
    a = 16'h0F00; b = 16'h0100; c_in = 1'b0; sub = 1'b0; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    for (int i = 0; i < 20 && !res_valid; i++) begin
      @(posedge clk); #1;
    end
    check("bp valid", 32'(res_valid), 32'd1);
    held_sum = sum; held_c = c_out; held_z = zero;
    check("bp sum", 32'(held_sum), 32'h1000);
    for (int i = 0; i < 5; i++) begin
      start_valid = (i == 2);
      @(posedge clk); #1;
      check("bp hold valid", 32'(res_valid), 32'd1);
      check("bp hold sum", 32'(sum), 32'(held_sum));
      check("bp hold flags", {30'd0, c_out, zero}, {30'd0, held_c, held_z});
      check("bp no ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    spurious = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid || busy) spurious++;
      @(posedge clk); #1;
    end
    check("bp no second result", 32'(spurious), 32'd0);

    // Reset in RUN at k=2 with a nonzero partial sum.
    a = 16'h1234; b = 16'h1111; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid busy", 32'(busy), 32'd1);
    rst = 1'b1; #1;
    check("mid rst ready low", 32'(start_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("mid rst ready", 32'(start_ready), 32'd1);
    check("mid rst valid", 32'(res_valid), 32'd0);
    check("mid rst sum", 32'(sum), 32'd0);
    check("mid rst flags", {30'd0, c_out, zero}, 32'd0);
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      if (res_valid || busy) spurious++;
      @(posedge clk); #1;
    end
    check("mid rst no result", 32'(spurious), 32'd0);
    do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Back-to-back with res_ready tied high: accepts exactly N+2 cycles apart.
    a = 16'h0102; b = 16'h0304; c_in = 1'b0; sub = 1'b0;
    start_valid = 1'b1; res_ready = 1'b1;
    n_acc = 0; n_res = 0;
    for (int i = 0; i < 40 && n_res < 2; i++) begin
      if (start_valid && start_ready && n_acc < 2) begin
        acc_t[n_acc] = cyc;
        n_acc++;
      end
      if (res_valid && n_res < 2) begin
        res_q[n_res] = sum;
        n_res++;
      end
      @(posedge clk); #1;
      if (n_acc == 1) begin a = 16'hFFF0; b = 16'h0020; end
      if (n_acc == 2) start_valid = 1'b0;
    end
    res_ready = 1'b0;
    check("b2b accepts", 32'(n_acc), 32'd2);
    check("b2b results", 32'(n_res), 32'd2);
    check("b2b interval", 32'(acc_t[1] - acc_t[0]), 32'(N + 2));
    check("b2b sum0", 32'(res_q[0]), 32'h0406);
    check("b2b sum1", 32'(res_q[1]), 32'h0010);

    check("ready/valid overlap", 32'(overlap_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
